multiport_ram: RTL and testbench



---
 rtl/multiport_ram_pkg.sv | 34 +++
 rtl/mp_write_arb.sv | 62 ++++++
 rtl/multiport_ram.sv | 201 ++++++++++++++++++++
 tb/tb_multiport_ram.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiport_ram_pkg.sv
// -----------------------------------------------------------------------------
// multiport_ram_pkg
// Shared definitions for the multiport_ram block and its write arbiter:
//   - state_e   : controller state (INIT sweep / RUN)
//   - clog2     : ceiling log2 for sizing address and counter fields
//   - sel_width : width of a port-index field (never narrower than 1 bit)
//   - MAX_PORTS / MAX_DEPTH : supported parameter limits
// No ports (package).
// -----------------------------------------------------------------------------
package multiport_ram_pkg;

  localparam int MAX_PORTS = 8;
  localparam int MAX_DEPTH = 1024;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A single-port configuration still needs a 1-bit select field.
  function automatic int sel_width(input int nports);
    return (nports > 1) ? clog2(nports) : 1;
  endfunction

endpackage

// File: rtl/mp_write_arb.sv
// -----------------------------------------------------------------------------
// mp_write_arb
// Purely combinational same-address write arbitration and read forwarding.
// The lowest-index port that writes a given address wins; any higher-index
// writer to that address loses and is flagged. For each port the block also
// reports whether some winning write targets that port's address and, if so,
// which port it was, so the read path can return the new data (write-first).
//
// Ports:
//   wr_req_i   [NPORTS]         qualified write requests (in range, accepted)
//   addr_i     [NPORTS*ADDR_W]  per-port address, port p at [p*ADDR_W +: ADDR_W]
//   grant_o    [NPORTS]         write commits this cycle
//   conflict_o [NPORTS]         write dropped, a lower-index port won
//   fwd_hit_o  [NPORTS]         a winning write targets this port's address
//   fwd_sel_o  [NPORTS*SEL_W]   index of that winning writer
// -----------------------------------------------------------------------------
module mp_write_arb
  import multiport_ram_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int ADDR_W = 9,
  parameter int SEL_W  = sel_width(NPORTS)
) (
  input  logic [NPORTS-1:0]        wr_req_i,
  input  logic [NPORTS*ADDR_W-1:0] addr_i,
  output logic [NPORTS-1:0]        grant_o,
  output logic [NPORTS-1:0]        conflict_o,
  output logic [NPORTS-1:0]        fwd_hit_o,
  output logic [NPORTS*SEL_W-1:0]  fwd_sel_o
);

  always_comb begin
    conflict_o = '0;
    grant_o    = '0;
    fwd_hit_o  = '0;
    fwd_sel_o  = '0;

    // A write loses if any lower-index port writes the same address.
    for (int p = 0; p < NPORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (wr_req_i[p] && wr_req_i[q] &&
            (addr_i[p*ADDR_W +: ADDR_W] == addr_i[q*ADDR_W +: ADDR_W])) begin
          conflict_o[p] = 1'b1;
        end
      end
    end

    grant_o = wr_req_i & ~conflict_o;

    // At most one granted writer exists per address, so the match is unique.
    for (int p = 0; p < NPORTS; p++) begin
      for (int q = 0; q < NPORTS; q++) begin
        if (grant_o[q] &&
            (addr_i[q*ADDR_W +: ADDR_W] == addr_i[p*ADDR_W +: ADDR_W])) begin
          fwd_hit_o[p]                 = 1'b1;
          fwd_sel_o[p*SEL_W +: SEL_W]  = SEL_W'(q);
        end
      end
    end
  end

endmodule

// File: rtl/multiport_ram.sv
// -----------------------------------------------------------------------------
// multiport_ram
// N-port register-file RAM. Every port may read and write each cycle; reads
// return registered data one cycle later. Same-address writes are resolved by
// port index (lowest wins), reads see same-cycle winning writes, out-of-range
// accesses are flagged and suppressed, and with INIT_ZERO=1 the whole array is
// cleared one word per cycle after reset before requests are accepted.
//
// Handshake: there is no backpressure per request. When ready is high every
// request presented on a cycle is accepted at that clock edge; when ready is
// low requests are ignored entirely. rvalid[p], wr_conflict[p] and
// addr_err[p] are single-cycle pulses in the cycle after the request.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   write_en     [NPORTS]          per-port write request
//   read_en      [NPORTS]          per-port read request
//   addr         [NPORTS*ADDR_W]   per-port address
//   data_in      [NPORTS*DATA_W]   per-port write data
//   data_out     [NPORTS*DATA_W]   per-port registered read data
//   rvalid       [NPORTS]          data_out[p] updated this cycle
//   wr_conflict  [NPORTS]          port's write lost arbitration
//   addr_err     [NPORTS]          port's address was >= DEPTH
//   ready        accepting requests
//   dbg_state_o  current controller state (state_e encoding)
// -----------------------------------------------------------------------------
module multiport_ram
  import multiport_ram_pkg::*;
#(
  parameter int NPORTS    = 4,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 9,
  parameter int INIT_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        write_en,
  input  logic [NPORTS-1:0]        read_en,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] data_in,
  output logic [NPORTS*DATA_W-1:0] data_out,
  output logic [NPORTS-1:0]        rvalid,
  output logic [NPORTS-1:0]        wr_conflict,
  output logic [NPORTS-1:0]        addr_err,
  output logic                     ready,
  output logic                     dbg_state_o
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int SEL_W = sel_width(NPORTS);
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic                     ready_q, ready_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];

  logic [NPORTS*DATA_W-1:0] dout_q, dout_d;
  logic [NPORTS-1:0]        rvalid_q, rvalid_d;
  logic [NPORTS-1:0]        conf_q, conf_d;
  logic [NPORTS-1:0]        err_q, err_d;

  // ---------------------------------------------------------------------------
  // Per-port request decode
  // ---------------------------------------------------------------------------
  logic                     accept;
  logic [NPORTS-1:0]        in_range;
  logic [NPORTS-1:0]        wr_req;
  logic [IDX_W-1:0]         idx [NPORTS];

  logic [NPORTS-1:0]        grant;
  logic [NPORTS-1:0]        conflict;
  logic [NPORTS-1:0]        fwd_hit;
  logic [NPORTS*SEL_W-1:0]  fwd_sel;

  // ready_q is also low for the first cycle after reset when INIT_ZERO=0,
  // so it alone decides acceptance; the state term documents intent.
  assign accept = ready_q && (state_q == ST_RUN);

  always_comb begin
    in_range = '0;
    wr_req   = '0;
    for (int p = 0; p < NPORTS; p++) begin
      in_range[p] = ({1'b0, addr[p*ADDR_W +: ADDR_W]} < DEPTH_L);
      wr_req[p]   = accept && write_en[p] && in_range[p];
      // Only meaningful when in_range[p]; the upper address bits are zero then.
      idx[p]      = addr[p*ADDR_W +: IDX_W];
    end
  end

  mp_write_arb #(
    .NPORTS (NPORTS),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_arb (
    .wr_req_i   (wr_req),
    .addr_i     (addr),
    .grant_o    (grant),
    .conflict_o (conflict),
    .fwd_hit_o  (fwd_hit),
    .fwd_sel_o  (fwd_sel)
  );

  // ---------------------------------------------------------------------------
  // Read path and flag next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    dout_d   = dout_q;
    rvalid_d = '0;
    err_d    = '0;
    conf_d   = conflict;
    for (int p = 0; p < NPORTS; p++) begin
      err_d[p] = accept && (write_en[p] || read_en[p]) && !in_range[p];
      if (accept && read_en[p]) begin
        rvalid_d[p] = 1'b1;
        if (!in_range[p]) begin
          dout_d[p*DATA_W +: DATA_W] = '0;
        end else if (fwd_hit[p]) begin
          dout_d[p*DATA_W +: DATA_W] =
            data_in[int'(fwd_sel[p*SEL_W +: SEL_W])*DATA_W +: DATA_W];
        end else begin
          dout_d[p*DATA_W +: DATA_W] = mem_q[idx[p]];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: INIT sweeps word cnt_q each cycle, then RUN until reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      dout_q   <= '0;
      rvalid_q <= '0;
      conf_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      conf_q   <= conf_d;
      err_q    <= err_d;
    end
  end

  // Memory array has no reset; it is only written outside reset, either by
  // the INIT sweep or by granted port writes (grants never share an address).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int p = 0; p < NPORTS; p++) begin
          if (grant[p]) begin
            mem_q[idx[p]] <= data_in[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign data_out    = dout_q;
  assign rvalid      = rvalid_q;
  assign wr_conflict = conf_q;
  assign addr_err    = err_q;
  assign ready       = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multiport_ram.sv
module tb_multiport_ram;

  localparam int NP    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 9;
  localparam int IW    = 5;
  localparam int EXP_W = NP*DW + 3*NP;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NP-1:0]    write_en, read_en;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] data_in;

  logic [NP*DW-1:0] data_out;
  logic [NP-1:0]    rvalid, wr_conflict, addr_err;
  logic             ready, dbg_state;

  logic [NP*DW-1:0] nz_data_out;
  logic [NP-1:0]    nz_rvalid, nz_wr_conflict, nz_addr_err;
  logic             nz_ready, nz_dbg_state;

  multiport_ram #(.NPORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .read_en(read_en),
    .addr(addr), .data_in(data_in), .data_out(data_out), .rvalid(rvalid),
    .wr_conflict(wr_conflict), .addr_err(addr_err), .ready(ready),
    .dbg_state_o(dbg_state)
  );

  multiport_ram #(.NPORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INIT_ZERO(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .read_en(read_en),
    .addr(addr), .data_in(data_in), .data_out(nz_data_out), .rvalid(nz_rvalid),
    .wr_conflict(nz_wr_conflict), .addr_err(nz_addr_err), .ready(nz_ready),
    .dbg_state_o(nz_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0]    mem_m [DEPTH];
  logic [NP*DW-1:0] dout_m;
  logic [EXP_W-1:0] exp_q[$];

  logic [NP-1:0]    we_v, re_v;
  logic [AW-1:0]    a_v [NP];
  logic [DW-1:0]    d_v [NP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [AW-1:0] a);
    return a < AW'(DEPTH);
  endfunction

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      addr[p*AW +: AW]    = a_v[p];
      data_in[p*DW +: DW] = d_v[p];
    end
    write_en = we_v;
    read_en  = re_v;
  endtask

  task automatic set_idle();
    we_v = '0;
    re_v = '0;
    for (int p = 0; p < NP; p++) begin
      a_v[p] = '0;
      d_v[p] = '0;
    end
    drive_inputs();
  endtask

  task automatic set_random(input int amax);
    we_v = NP'($urandom);
    re_v = NP'($urandom);
    for (int p = 0; p < NP; p++) begin
      a_v[p] = AW'($urandom_range(0, amax));
      d_v[p] = DW'($urandom);
    end
  endtask

  // One accepted cycle: the first writer (by port order) to claim a word owns
  // it; reads return the word as it stands after the cycle's writes.
  task automatic model_step();
    logic [DW-1:0] next_mem [DEPTH];
    bit            claimed  [DEPTH];
    logic [NP-1:0] rv, cf, er;
    next_mem = mem_m;
    for (int i = 0; i < DEPTH; i++) claimed[i] = 1'b0;
    rv = '0; cf = '0; er = '0;
    for (int p = 0; p < NP; p++) begin
      if ((we_v[p] || re_v[p]) && !in_rng(a_v[p])) er[p] = 1'b1;
      if (we_v[p] && in_rng(a_v[p])) begin
        if (claimed[a_v[p][IW-1:0]]) cf[p] = 1'b1;
        else begin
          claimed[a_v[p][IW-1:0]]  = 1'b1;
          next_mem[a_v[p][IW-1:0]] = d_v[p];
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (re_v[p]) begin
        rv[p] = 1'b1;
        dout_m[p*DW +: DW] = in_rng(a_v[p]) ? next_mem[a_v[p][IW-1:0]] : '0;
      end
    end
    mem_m = next_mem;
    exp_q.push_back({dout_m, rv, cf, er});
  endtask

  task automatic apply_and_check(input string tag);
    logic [EXP_W-1:0] e;
    drive_inputs();
    model_step();
    tick();
    e = exp_q.pop_front();
    check({tag, "_dout"},   64'(data_out),    64'(e[EXP_W-1 -: NP*DW]));
    check({tag, "_rvalid"}, 64'(rvalid),      64'(e[3*NP-1 -: NP]));
    check({tag, "_conf"},   64'(wr_conflict), 64'(e[2*NP-1 -: NP]));
    check({tag, "_err"},    64'(addr_err),    64'(e[NP-1:0]));
    check({tag, "_ready"},  64'(ready),       64'(1));
  endtask

  // Reset for one cycle with busy inputs, optionally abort the sweep after
  // abort_at cycles, then count cycles until ready rises.
  task automatic reset_and_sweep(input int abort_at, output int cycles);
    rst_n = 1'b0;
    set_random(40);
    drive_inputs();
    tick();
    check("rst_dout",     64'(data_out),    64'(0));
    check("rst_rvalid",   64'(rvalid),      64'(0));
    check("rst_conf",     64'(wr_conflict), 64'(0));
    check("rst_err",      64'(addr_err),    64'(0));
    check("rst_ready",    64'(ready),       64'(0));
    check("rst_nz_ready", 64'(nz_ready),    64'(0));
    rst_n = 1'b1;
    if (abort_at > 0) begin
      for (int k = 0; k < abort_at; k++) begin
        set_random(40); re_v = '1; drive_inputs();
        tick();
        check("init_ready_pre", 64'(ready),  64'(0));
        check("init_rvalid",    64'(rvalid), 64'(0));
      end
      rst_n = 1'b0;
      tick();
      check("abort_ready", 64'(ready), 64'(0));
      rst_n = 1'b1;
    end
    cycles = 0;
    for (int k = 1; k <= 100; k++) begin
      set_random(40); re_v = '1; drive_inputs();
      tick();
      if (k == 1) check("nz_ready_first", 64'(nz_ready), 64'(1));
      if (ready) begin
        cycles = k;
        break;
      end
      check("init_rvalid", 64'(rvalid),      64'(0));
      check("init_err",    64'(addr_err),    64'(0));
      check("init_conf",   64'(wr_conflict), 64'(0));
    end
    if (cycles == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sweep_timeout: ready never rose within 100 cycles");
    end
    set_idle();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    dout_m = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [NP-1:0]    we;
    logic [NP-1:0]    re;
    logic [NP*AW-1:0] a;
    logic [NP*DW-1:0] d;
    logic [NP*DW-1:0] x;
    logic [NP-1:0]    rv;
    logic [NP-1:0]    cf;
    logic [NP-1:0]    er;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cyc;
    logic [EXP_W-1:0] junk;

    tbl[0] = '{we:4'b1111, re:4'b0000, a:{9'd4, 9'd3, 9'd2, 9'd1},
               d:{16'h4444, 16'h3333, 16'h2222, 16'h1111}, x:64'h0,
               rv:4'b0000, cf:4'b0000, er:4'b0000};
    tbl[1] = '{we:4'b0000, re:4'b1111, a:{9'd1, 9'd2, 9'd3, 9'd4}, d:64'h0,
               x:{16'h1111, 16'h2222, 16'h3333, 16'h4444},
               rv:4'b1111, cf:4'b0000, er:4'b0000};
    tbl[2] = '{we:4'b1010, re:4'b0001, a:{9'd7, 9'd0, 9'd7, 9'd7},
               d:{16'h5555, 16'h0000, 16'hAAAA, 16'h0000},
               x:{16'h0, 16'h0, 16'h0, 16'hAAAA}, rv:4'b0001, cf:4'b1000, er:4'b0000};
    tbl[3] = '{we:4'b0000, re:4'b0100, a:{9'd0, 9'd7, 9'd0, 9'd0}, d:64'h0,
               x:{16'h0, 16'hAAAA, 16'h0, 16'h0}, rv:4'b0100, cf:4'b0000, er:4'b0000};
    tbl[4] = '{we:4'b0001, re:4'b0100, a:{9'd0, 9'd9, 9'd0, 9'd9},
               d:{16'h0, 16'h0, 16'h0, 16'hCAFE},
               x:{16'h0, 16'hCAFE, 16'h0, 16'h0}, rv:4'b0100, cf:4'b0000, er:4'b0000};
    tbl[5] = '{we:4'b0010, re:4'b1000, a:{9'd40, 9'd0, 9'd40, 9'd0},
               d:{16'h0, 16'h0, 16'hBBBB, 16'h0}, x:64'h0,
               rv:4'b1000, cf:4'b0000, er:4'b1010};
    tbl[6] = '{we:4'b1100, re:4'b0111, a:{9'd9, 9'd9, 9'd9, 9'd8},
               d:{16'h1234, 16'h5678, 16'h0, 16'h0},
               x:{16'h0, 16'h5678, 16'h5678, 16'h0}, rv:4'b0111, cf:4'b1000, er:4'b0000};
    tbl[7] = '{we:4'b0001, re:4'b0110, a:{9'd0, 9'd0, 9'd31, 9'd32},
               d:{16'h0, 16'h0, 16'h0, 16'hFFFF}, x:64'h0,
               rv:4'b0110, cf:4'b0000, er:4'b0001};
    tbl[8] = '{we:4'b0000, re:4'b0011, a:{9'd0, 9'd0, 9'd32, 9'd0}, d:64'h0,
               x:64'h0, rv:4'b0011, cf:4'b0000, er:4'b0010};
    tbl[9] = '{we:4'b0000, re:4'b0000, a:64'h0, d:64'h0, x:64'h0,
               rv:4'b0000, cf:4'b0000, er:4'b0000};

    rst_n = 1'b0;
    set_idle();

    // Power-up reset and full sweep.
    reset_and_sweep(0, cyc);
    check("init_len", 64'(cyc), 64'(DEPTH));

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      we_v = tbl[i].we;
      re_v = tbl[i].re;
      for (int p = 0; p < NP; p++) begin
        a_v[p] = tbl[i].a[p*AW +: AW];
        d_v[p] = tbl[i].d[p*DW +: DW];
      end
      drive_inputs();
      model_step();
      tick();
      junk = exp_q.pop_front();
      for (int p = 0; p < NP; p++) begin
        if (tbl[i].rv[p])
          check($sformatf("vec%0d_dout%0d", i, p), 64'(data_out[p*DW +: DW]),
                64'(tbl[i].x[p*DW +: DW]));
      end
      check($sformatf("vec%0d_rvalid", i), 64'(rvalid),      64'(tbl[i].rv));
      check($sformatf("vec%0d_conf", i),   64'(wr_conflict), 64'(tbl[i].cf));
      check($sformatf("vec%0d_err", i),    64'(addr_err),    64'(tbl[i].er));
    end

    // Randomized traffic against the model; a narrow address range half the
    // time makes same-address collisions and forwarding frequent.
    for (int i = 0; i < 400; i++) begin
      set_random(($urandom_range(0, 1) == 0) ? 7 : 35);
      apply_and_check($sformatf("rnd%0d", i));
    end

    // Preload a word, reset, and confirm the sweep cleared it.
    set_idle();
    we_v[0] = 1'b1; a_v[0] = 9'd5; d_v[0] = 16'hBEEF;
    apply_and_check("preload_wr");
    set_idle();
    re_v[1] = 1'b1; a_v[1] = 9'd5;
    apply_and_check("preload_rd");
    reset_and_sweep(0, cyc);
    check("init_len2", 64'(cyc), 64'(DEPTH));
    set_idle();
    re_v[2] = 1'b1; a_v[2] = 9'd5;
    apply_and_check("cleared_rd");
    check("cleared_word5", 64'(data_out[2*DW +: DW]), 64'(16'h0000));

    // Reset during the sweep restarts it from word 0.
    reset_and_sweep(10, cyc);
    check("init_len_abort", 64'(cyc), 64'(DEPTH));
    set_random(31);
    apply_and_check("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
